// File: rtl/control_pkg.sv
// Shared constants for the multi-cycle control unit: opcode map, ALU
// operation codes, FSM state encoding, writeback sources and the opcode
// class bundle produced by the decoder.
package control_pkg;

    localparam int unsigned STATE_WIDTH = 3;
    localparam int unsigned WAIT_WIDTH  = 4;

    // Opcode map
    localparam int unsigned OP_ADD  = 'h00;
    localparam int unsigned OP_ADDI = 'h01;
    localparam int unsigned OP_SUB  = 'h02;
    localparam int unsigned OP_SUBI = 'h03;
    localparam int unsigned OP_NOP  = 'h04;
    localparam int unsigned OP_HALT = 'h05;
    localparam int unsigned OP_JUMP = 'h06;
    localparam int unsigned OP_BEQ  = 'h07;
    localparam int unsigned OP_BNE  = 'h08;
    localparam int unsigned OP_SLT  = 'h09;
    localparam int unsigned OP_LW   = 'h0A;
    localparam int unsigned OP_LI   = 'h0B;
    localparam int unsigned OP_IN   = 'h0C;
    localparam int unsigned OP_OUT  = 'h0D;
    localparam int unsigned OP_SW   = 'h0E;
    localparam int unsigned OP_AND  = 'h0F;
    localparam int unsigned OP_ANDI = 'h10;
    localparam int unsigned OP_OR   = 'h11;
    localparam int unsigned OP_ORI  = 'h12;
    localparam int unsigned OP_NOT  = 'h13;
    localparam int unsigned OP_XOR  = 'h14;
    localparam int unsigned OP_XORI = 'h15;
    localparam int unsigned OP_SLL  = 'h16;
    localparam int unsigned OP_SRL  = 'h17;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLT = 4'd2;
    localparam logic [3:0] ALU_NOT = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;

    // FSM state encoding (also visible on the debug port)
    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_WAIT_IO   = 3'd5;
    localparam logic [2:0] S_HALTED    = 3'd6;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IN  = 2'd2;

    // Opcode class flags; all-zero means nop (including undefined opcodes)
    typedef struct packed {
        logic is_alu;
        logic is_imm;
        logic is_li;
        logic is_lw;
        logic is_sw;
        logic is_jump;
        logic is_beq;
        logic is_bne;
        logic is_in;
        logic is_out;
        logic is_halt;
    } op_class_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode decoder.
// Ports: opcode in; aluop, register_destiny_selector, alu_input2_selector,
// alu_mem_output_selector and the op_class flag bundle out.
module control_decoder
    import control_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 5,
    parameter int unsigned ALUOP_WIDTH  = 4
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ALUOP_WIDTH-1:0]  aluop,
    output logic                    register_destiny_selector,
    output logic                    alu_input2_selector,
    output logic [1:0]              alu_mem_output_selector,
    output op_class_t               op_class
);

    logic [3:0] alu_code;

    // Opcode -> class flags and ALU operation
    always_comb begin
        op_class = '0;
        alu_code = ALU_ADD;
        case (opcode)
            OPCODE_WIDTH'(OP_ADD):  op_class.is_alu = 1'b1;
            OPCODE_WIDTH'(OP_ADDI): begin op_class.is_alu = 1'b1; op_class.is_imm = 1'b1; end
            OPCODE_WIDTH'(OP_SUB):  begin op_class.is_alu = 1'b1; alu_code = ALU_SUB; end
            OPCODE_WIDTH'(OP_SUBI): begin op_class.is_alu = 1'b1; op_class.is_imm = 1'b1; alu_code = ALU_SUB; end
            OPCODE_WIDTH'(OP_HALT): op_class.is_halt = 1'b1;
            OPCODE_WIDTH'(OP_JUMP): op_class.is_jump = 1'b1;
            OPCODE_WIDTH'(OP_BEQ):  begin op_class.is_beq = 1'b1; alu_code = ALU_SUB; end
            OPCODE_WIDTH'(OP_BNE):  begin op_class.is_bne = 1'b1; alu_code = ALU_SUB; end
            OPCODE_WIDTH'(OP_SLT):  begin op_class.is_alu = 1'b1; alu_code = ALU_SLT; end
            OPCODE_WIDTH'(OP_LW):   op_class.is_lw = 1'b1;
            OPCODE_WIDTH'(OP_LI):   op_class.is_li = 1'b1;
            OPCODE_WIDTH'(OP_IN):   op_class.is_in = 1'b1;
            OPCODE_WIDTH'(OP_OUT):  op_class.is_out = 1'b1;
            OPCODE_WIDTH'(OP_SW):   op_class.is_sw = 1'b1;
            OPCODE_WIDTH'(OP_AND):  begin op_class.is_alu = 1'b1; alu_code = ALU_AND; end
            OPCODE_WIDTH'(OP_ANDI): begin op_class.is_alu = 1'b1; op_class.is_imm = 1'b1; alu_code = ALU_AND; end
            OPCODE_WIDTH'(OP_OR):   begin op_class.is_alu = 1'b1; alu_code = ALU_OR; end
            OPCODE_WIDTH'(OP_ORI):  begin op_class.is_alu = 1'b1; op_class.is_imm = 1'b1; alu_code = ALU_OR; end
            OPCODE_WIDTH'(OP_NOT):  begin op_class.is_alu = 1'b1; alu_code = ALU_NOT; end
            OPCODE_WIDTH'(OP_XOR):  begin op_class.is_alu = 1'b1; alu_code = ALU_XOR; end
            OPCODE_WIDTH'(OP_XORI): begin op_class.is_alu = 1'b1; op_class.is_imm = 1'b1; alu_code = ALU_XOR; end
            OPCODE_WIDTH'(OP_SLL):  begin op_class.is_alu = 1'b1; alu_code = ALU_SLL; end
            OPCODE_WIDTH'(OP_SRL):  begin op_class.is_alu = 1'b1; alu_code = ALU_SRL; end
            default: ;
        endcase
    end

    assign aluop = ALUOP_WIDTH'(alu_code);

    // Datapath mux selects derived from the class flags
    assign register_destiny_selector = op_class.is_imm | op_class.is_lw | op_class.is_li | op_class.is_in;
    assign alu_input2_selector       = op_class.is_imm | op_class.is_lw | op_class.is_li | op_class.is_sw;
    assign alu_mem_output_selector   = op_class.is_lw ? WB_MEM : (op_class.is_in ? WB_IN : WB_ALU);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK plus
// WAIT_IO (valid/ready I/O) and HALTED (resume on rising edge).
// Ports: clock, reset (sync, active-low); opcode, zero_alu, input_valid,
// output_ready, resume in; datapath selects, write strobes, input_ack,
// halt, io_wait, state (debug) and retired-instruction count out.
// Strobes and selects are decoded from the current state in the same cycle
// (the I/O handshake completes in the cycle valid/ready is seen) and are
// forced low while reset is asserted.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 5,
    parameter int unsigned ALUOP_WIDTH  = 4,
    parameter int unsigned MEM_WAIT     = 1,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero_alu,
    input  logic                    input_valid,
    input  logic                    output_ready,
    input  logic                    resume,
    output logic                    instruction_load,
    output logic                    pc_write,
    output logic                    pc_selector,
    output logic                    register_destiny_selector,
    output logic                    alu_input2_selector,
    output logic [1:0]              alu_mem_output_selector,
    output logic [ALUOP_WIDTH-1:0]  aluop_selector,
    output logic                    register_write_enabled,
    output logic                    memory_write_enabled,
    output logic                    output_write_enabled,
    output logic                    input_ack,
    output logic                    halt,
    output logic                    io_wait,
    output logic [2:0]              state,
    output logic [COUNT_WIDTH-1:0]  retired
);

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [WAIT_WIDTH-1:0]  wait_q, wait_d;
    logic                   resume_q;
    logic [COUNT_WIDTH-1:0] retired_q;

    logic [ALUOP_WIDTH-1:0] dec_aluop;
    logic                   dec_reg_dst;
    logic                   dec_alu_src;
    logic [1:0]             dec_wb_sel;
    op_class_t              cls;

    logic il_c, pw_c, ps_c, rwe_c, mwe_c, owe_c, ack_c, halt_c, iow_c;
    logic sel_en;
    logic resume_edge;

    control_decoder #(
        .OPCODE_WIDTH(OPCODE_WIDTH),
        .ALUOP_WIDTH (ALUOP_WIDTH)
    ) u_decoder (
        .opcode                   (opcode),
        .aluop                    (dec_aluop),
        .register_destiny_selector(dec_reg_dst),
        .alu_input2_selector      (dec_alu_src),
        .alu_mem_output_selector  (dec_wb_sel),
        .op_class                 (cls)
    );

    assign resume_edge = resume & ~resume_q;

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        il_c    = 1'b0;
        pw_c    = 1'b0;
        ps_c    = 1'b0;
        rwe_c   = 1'b0;
        mwe_c   = 1'b0;
        owe_c   = 1'b0;
        ack_c   = 1'b0;
        halt_c  = 1'b0;
        iow_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                il_c    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls.is_halt) begin
                    state_d = S_HALTED;
                end else if (cls.is_in || cls.is_out) begin
                    state_d = S_WAIT_IO;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (cls.is_alu || cls.is_li) begin
                    state_d = S_WRITEBACK;
                end else if (cls.is_lw) begin
                    state_d = S_MEMORY;
                    wait_d  = WAIT_WIDTH'(MEM_WAIT - 1);
                end else begin
                    // sw, jump, branches and nop retire straight from EXECUTE
                    pw_c    = 1'b1;
                    mwe_c   = cls.is_sw;
                    ps_c    = cls.is_jump | (cls.is_beq & zero_alu) | (cls.is_bne & ~zero_alu);
                    state_d = S_FETCH;
                end
            end
            S_MEMORY: begin
                if (wait_q == '0) begin
                    state_d = S_WRITEBACK;
                end else begin
                    wait_d = wait_q - WAIT_WIDTH'(1);
                end
            end
            S_WRITEBACK: begin
                rwe_c   = 1'b1;
                pw_c    = 1'b1;
                state_d = S_FETCH;
            end
            S_WAIT_IO: begin
                iow_c = 1'b1;
                if (cls.is_in && input_valid) begin
                    rwe_c   = 1'b1;
                    ack_c   = 1'b1;
                    pw_c    = 1'b1;
                    state_d = S_FETCH;
                end else if (cls.is_out && output_ready) begin
                    owe_c   = 1'b1;
                    pw_c    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                halt_c = 1'b1;
                if (resume_edge) begin
                    pw_c    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State, wait counter, resume history and retired count
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            resume_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            resume_q <= resume;
            if (pw_c) begin
                retired_q <= retired_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Selects follow the decoded opcode from DECODE onward; everything is
    // held low while reset is asserted.
    assign sel_en = reset & (state_q != S_FETCH);

    assign instruction_load          = reset & il_c;
    assign pc_write                  = reset & pw_c;
    assign pc_selector               = reset & ps_c;
    assign register_write_enabled    = reset & rwe_c;
    assign memory_write_enabled      = reset & mwe_c;
    assign output_write_enabled      = reset & owe_c;
    assign input_ack                 = reset & ack_c;
    assign halt                      = reset & halt_c;
    assign io_wait                   = reset & iow_c;
    assign register_destiny_selector = sel_en & dec_reg_dst;
    assign alu_input2_selector       = sel_en & dec_alu_src;
    assign alu_mem_output_selector   = sel_en ? dec_wb_sel : 2'd0;
    assign aluop_selector            = sel_en ? dec_aluop : '0;

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level timeline model
// produces the expected outputs of every cycle; one compare process checks
// them on the falling edge, plus literal checks on cycle counts and retired.
module tb_multicycle_control_unit;

    localparam int MW = 3;

    localparam int K_ALU  = 0;
    localparam int K_LW   = 1;
    localparam int K_SW   = 2;
    localparam int K_JMP  = 3;
    localparam int K_BEQ  = 4;
    localparam int K_BNE  = 5;
    localparam int K_IN   = 6;
    localparam int K_OUT  = 7;
    localparam int K_HALT = 8;
    localparam int K_NOP  = 9;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  opcode;
    logic        zero_alu, input_valid, output_ready, resume;
    logic        instruction_load, pc_write, pc_selector;
    logic        register_destiny_selector, alu_input2_selector;
    logic [1:0]  alu_mem_output_selector;
    logic [3:0]  aluop_selector;
    logic        register_write_enabled, memory_write_enabled, output_write_enabled;
    logic        input_ack, halt, io_wait;
    logic [2:0]  state;
    logic [15:0] retired;

    typedef struct packed {
        logic [2:0] st;
        logic       il, pw, ps, rd, a2;
        logic [1:0] ms;
        logic [3:0] aop;
        logic       rwe, mwe, owe, ack, hlt, iow;
    } obs_t;

    obs_t        exp_cur;
    logic [15:0] exp_ret;
    logic [15:0] m_ret;
    bit          chk_en;
    int          tests;
    int          fails;
    int          nsteps;
    int          cyc;

    always #5 clock = ~clock;

    multicycle_control_unit #(
        .OPCODE_WIDTH(5),
        .ALUOP_WIDTH (4),
        .MEM_WAIT    (MW),
        .COUNT_WIDTH (16)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .opcode                   (opcode),
        .zero_alu                 (zero_alu),
        .input_valid              (input_valid),
        .output_ready             (output_ready),
        .resume                   (resume),
        .instruction_load         (instruction_load),
        .pc_write                 (pc_write),
        .pc_selector              (pc_selector),
        .register_destiny_selector(register_destiny_selector),
        .alu_input2_selector      (alu_input2_selector),
        .alu_mem_output_selector  (alu_mem_output_selector),
        .aluop_selector           (aluop_selector),
        .register_write_enabled   (register_write_enabled),
        .memory_write_enabled     (memory_write_enabled),
        .output_write_enabled     (output_write_enabled),
        .input_ack                (input_ack),
        .halt                     (halt),
        .io_wait                  (io_wait),
        .state                    (state),
        .retired                  (retired)
    );

    // Opcode tables taken straight from the instruction set description
    function automatic int kind_of(input int op);
        case (op)
            0, 1, 2, 3, 9, 11, 15, 16, 17, 18, 19, 20, 21, 22, 23: return K_ALU;
            10: return K_LW;
            14: return K_SW;
            6:  return K_JMP;
            7:  return K_BEQ;
            8:  return K_BNE;
            12: return K_IN;
            13: return K_OUT;
            5:  return K_HALT;
            default: return K_NOP;
        endcase
    endfunction

    function automatic int aop_of(input int op);
        case (op)
            2, 3, 7, 8: return 1;
            9:          return 2;
            19:         return 3;
            15, 16:     return 4;
            17, 18:     return 5;
            20, 21:     return 6;
            22:         return 7;
            23:         return 8;
            default:    return 0;
        endcase
    endfunction

    function automatic bit is_imm(input int op);
        return (op == 1) || (op == 3) || (op == 16) || (op == 18) || (op == 21);
    endfunction

    function automatic obs_t base(input int op, input logic [2:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        if (st != 3'd0) begin
            e.rd  = is_imm(op) || op == 10 || op == 11 || op == 12;
            e.a2  = is_imm(op) || op == 10 || op == 11 || op == 14;
            e.ms  = (op == 10) ? 2'd1 : ((op == 12) ? 2'd2 : 2'd0);
            e.aop = 4'(aop_of(op));
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle of the timeline: publish expectation, advance, account retire
    task automatic step(input obs_t e);
        exp_cur = e;
        exp_ret = m_ret;
        chk_en  = 1'b1;
        @(posedge clock);
        #1;
        if (e.pw) m_ret = m_ret + 16'd1;
        nsteps++;
    endtask

    task automatic run(input int op, input logic z, input int nwait, output int ncyc);
        obs_t e;
        int   k;
        int   start;
        k = kind_of(op);
        start = nsteps;
        opcode = 5'(op);
        zero_alu = z;
        input_valid = 1'b0;
        output_ready = 1'b0;
        e = base(op, 3'd0); e.il = 1'b1; step(e);
        e = base(op, 3'd1); step(e);
        case (k)
            K_IN, K_OUT: begin
                for (int i = 0; i < nwait; i++) begin
                    // the other handshake line is high and must be ignored
                    input_valid  = (k == K_OUT);
                    output_ready = (k == K_IN);
                    e = base(op, 3'd5); e.iow = 1'b1; step(e);
                end
                input_valid  = (k == K_IN);
                output_ready = (k == K_OUT);
                e = base(op, 3'd5); e.iow = 1'b1; e.pw = 1'b1;
                if (k == K_IN) begin e.rwe = 1'b1; e.ack = 1'b1; end
                else e.owe = 1'b1;
                step(e);
                input_valid  = 1'b0;
                output_ready = 1'b0;
            end
            K_ALU: begin
                e = base(op, 3'd2); step(e);
                e = base(op, 3'd4); e.rwe = 1'b1; e.pw = 1'b1; step(e);
            end
            K_LW: begin
                e = base(op, 3'd2); step(e);
                for (int i = 0; i < MW; i++) begin
                    e = base(op, 3'd3); step(e);
                end
                e = base(op, 3'd4); e.rwe = 1'b1; e.pw = 1'b1; step(e);
            end
            default: begin
                e = base(op, 3'd2); e.pw = 1'b1;
                if (k == K_SW)  e.mwe = 1'b1;
                if (k == K_JMP) e.ps = 1'b1;
                if (k == K_BEQ) e.ps = z;
                if (k == K_BNE) e.ps = ~z;
                step(e);
            end
        endcase
        ncyc = nsteps - start;
    endtask

    task automatic run_halt(input logic pre_high, input int hold, output int ncyc);
        obs_t e;
        int   start;
        start = nsteps;
        opcode = 5'd5;
        resume = pre_high;
        e = base(5, 3'd0); e.il = 1'b1; step(e);
        e = base(5, 3'd1); step(e);
        for (int i = 0; i < hold; i++) begin
            e = base(5, 3'd6); e.hlt = 1'b1; step(e);
        end
        resume = 1'b0;
        e = base(5, 3'd6); e.hlt = 1'b1; step(e);
        resume = 1'b1;
        e = base(5, 3'd6); e.hlt = 1'b1; e.pw = 1'b1; step(e);
        ncyc = nsteps - start;
    endtask

    // Compare process
    initial begin
        fork
            forever begin
                @(negedge clock);
                if (chk_en) begin
                    obs_t act;
                    act.st  = state;
                    act.il  = instruction_load;
                    act.pw  = pc_write;
                    act.ps  = pc_selector;
                    act.rd  = register_destiny_selector;
                    act.a2  = alu_input2_selector;
                    act.ms  = alu_mem_output_selector;
                    act.aop = aluop_selector;
                    act.rwe = register_write_enabled;
                    act.mwe = memory_write_enabled;
                    act.owe = output_write_enabled;
                    act.ack = input_ack;
                    act.hlt = halt;
                    act.iow = io_wait;
                    tests++;
                    if (act !== exp_cur) begin
                        fails++;
                        $display("FAIL outputs t=%0t op=%0h: got %h expected %h", $time, opcode, act, exp_cur);
                    end
                    tests++;
                    if (retired !== exp_ret) begin
                        fails++;
                        $display("FAIL retired t=%0t: got %0d expected %0d", $time, retired, exp_ret);
                    end
                end
            end
        join_none
    end

    initial begin
        obs_t e;
        tests = 0; fails = 0; nsteps = 0; m_ret = 16'd0; chk_en = 1'b0;
        reset = 1'b0; opcode = 5'd0; zero_alu = 1'b0;
        input_valid = 1'b0; output_ready = 1'b0; resume = 1'b0;
        exp_cur = '0; exp_ret = 16'd0;

        @(posedge clock);
        #1;
        e = '0; step(e);
        reset = 1'b1;

        run(0, 1'b1, 0, cyc);
        check("add_cycles", cyc, 4);
        check("add_retired", int'(retired), 1);

        run(10, 1'b0, 0, cyc);
        check("lw_cycles", cyc, 7);
        check("lw_retired", int'(retired), 2);

        run(7, 1'b1, 0, cyc);
        check("beq_taken_cycles", cyc, 3);
        run(7, 1'b0, 0, cyc);
        run(8, 1'b1, 0, cyc);
        run(8, 1'b0, 0, cyc);
        check("bne_cycles", cyc, 3);

        // Sweep of every non-I/O, non-halt opcode with alternating zero flag
        for (int op = 0; op < 24; op++) begin
            if (op != 5 && op != 12 && op != 13) run(op, 1'(op & 1), 0, cyc);
        end

        run(12, 1'b0, 5, cyc);
        check("in_wait5_cycles", cyc, 8);
        run(12, 1'b0, 0, cyc);
        check("in_ready_cycles", cyc, 3);
        run(13, 1'b1, 2, cyc);
        check("out_wait2_cycles", cyc, 5);
        run(13, 1'b0, 0, cyc);

        run_halt(1'b1, 3, cyc);
        check("halt_held_cycles", cyc, 7);
        run_halt(1'b0, 2, cyc);
        resume = 1'b0;

        // Reset asserted while in MEMORY of a load
        opcode = 5'h0A;
        e = base(10, 3'd0); e.il = 1'b1; step(e);
        e = base(10, 3'd1); step(e);
        e = base(10, 3'd2); step(e);
        reset = 1'b0;
        e = '0; e.st = 3'd3; step(e);
        m_ret = 16'd0;
        e = '0; step(e);
        check("reset_retired", int'(retired), 0);
        reset = 1'b1;

        run(31, 1'b1, 0, cyc);
        check("undef_cycles", cyc, 3);
        check("undef_retired", int'(retired), 1);

        run(10, 1'b0, 0, cyc);
        check("lw_after_reset_retired", int'(retired), 2);

        chk_en = 1'b0;
        @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
